// File: rtl/mult_accumulator.sv
// Accumulates a run of unsigned 8-bit products from a 4x4 multiplier into an
// ACC_W-bit sum, presenting the result with a valid/ready handshake.
module mult_accumulator #(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       p_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       len,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc_p0;
  logic [4:0]       cnt_p0;
  logic [4:0]       len_p0;
  logic             ovf_p0;

  logic             accept;
  logic [4:0]       len_eff;
  logic [4:0]       cnt_inc;
  logic [ACC_W:0]   sum;

  // Modulo add that also returns the carry out of the top accumulator bit.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [7:0] p);
    return {1'b0, a} + (ACC_W+1)'(p);
  endfunction

  assign in_ready  = ena && (state != HOLD);
  assign accept    = in_valid && in_ready;
  assign len_eff   = (len == 4'd0) ? 5'd16 : {1'b0, len};
  assign cnt_inc   = cnt_p0 + 5'd1;
  assign sum       = acc_add(acc_p0, p_in);
  assign acc_out   = acc_p0;
  assign ovf       = ovf_p0;
  assign acc_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (len_eff == 5'd1) ? HOLD : ACCUM;
      ACCUM:   if (accept && (cnt_inc == len_p0)) state_nxt = HOLD;
      HOLD:    if (acc_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: accumulator stage; the final accept and the HOLD entry share one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc_p0 <= '0;
      cnt_p0 <= '0;
      len_p0 <= '0;
      ovf_p0 <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        state  <= IDLE;
        acc_p0 <= '0;
        cnt_p0 <= '0;
        ovf_p0 <= 1'b0;
      end else begin
        state <= state_nxt;
        if (accept) begin
          if (state == IDLE) begin
            len_p0 <= len_eff;
            acc_p0 <= ACC_W'(p_in);
            cnt_p0 <= 5'd1;
            ovf_p0 <= 1'b0;
          end else begin
            acc_p0 <= sum[ACC_W-1:0];
            cnt_p0 <= cnt_inc;
            if (sum[ACC_W]) ovf_p0 <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: two widths (12 and 8) driven in parallel and
// compared each cycle against a sequence-level model built on the true sum.
module tb_mult_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena, in_valid, clear, acc_ready;
  logic [7:0] p_in;
  logic [3:0] len;

  logic        rdy12, av12, ovf12, busy12;
  logic        rdy8, av8, ovf8, busy8;
  logic [11:0] out12;
  logic [7:0]  out8;

  mult_accumulator #(.ACC_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .p_in(p_in), .in_valid(in_valid),
    .in_ready(rdy12), .len(len), .clear(clear), .acc_out(out12),
    .acc_valid(av12), .acc_ready(acc_ready), .ovf(ovf12), .busy(busy12)
  );

  mult_accumulator #(.ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .p_in(p_in), .in_valid(in_valid),
    .in_ready(rdy8), .len(len), .clear(clear), .acc_out(out8),
    .acc_valid(av8), .acc_ready(acc_ready), .ovf(ovf8), .busy(busy8)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: phase of the current sequence, its length, products taken, and
  // the exact (unbounded) running total; outputs derive from total mod 2^W.
  localparam int M_IDLE = 0, M_ACC = 1, M_HOLD = 2;
  int ms = M_IDLE;
  int mlen = 0, mcnt = 0, total = 0;
  int accepts = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model();
    if (!rst_n) begin
      ms = M_IDLE; total = 0; mcnt = 0;
    end else if (ena) begin
      if (clear) begin
        ms = M_IDLE; total = 0; mcnt = 0;
      end else begin
        case (ms)
          M_IDLE: if (in_valid) begin
            mlen = (len == 0) ? 16 : int'(len);
            total = int'(p_in); mcnt = 1; accepts++;
            ms = (mlen == 1) ? M_HOLD : M_ACC;
          end
          M_ACC: if (in_valid) begin
            total += int'(p_in); mcnt++; accepts++;
            if (mcnt == mlen) ms = M_HOLD;
          end
          default: if (acc_ready) ms = M_IDLE;
        endcase
      end
    end
  endtask

  task automatic compare();
    chk("in_ready12", rdy12, ena && ms != M_HOLD);
    chk("in_ready8",  rdy8,  ena && ms != M_HOLD);
    chk("acc_valid12", av12, ms == M_HOLD);
    chk("acc_valid8",  av8,  ms == M_HOLD);
    chk("busy12", busy12, ms != M_IDLE);
    chk("busy8",  busy8,  ms != M_IDLE);
    chk("acc_out12", out12, total % 4096);
    chk("acc_out8",  out8,  total % 256);
    chk("ovf12", ovf12, total >= 4096);
    chk("ovf8",  ovf8,  total >= 256);
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    compare();
  endtask

  task automatic step(input bit v, input logic [7:0] p, input logic [3:0] l,
                      input bit c = 1'b0, input bit ar = 1'b0, input bit e = 1'b1);
    in_valid = v; p_in = p; len = l; clear = c; acc_ready = ar; ena = e;
    tick();
  endtask

  initial begin
    int a0;
    logic [11:0] held;
    rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; clear = 1'b0; acc_ready = 1'b0;
    p_in = 8'd0; len = 4'd0;
    tick();
    tick();
    chk("reset_out", out12, 0);
    chk("reset_busy", busy12, 0);
    rst_n = 1'b1;

    // Four back-to-back 225s with len=4: valid on the 4th accept edge.
    step(1, 225, 4);
    step(1, 225, 7);
    step(1, 225, 7);
    chk("r033_not_yet", av12, 0);
    step(1, 225, 7);
    chk("r033_valid", av12, 1);
    chk("r033_sum", out12, 900);
    chk("r033_ovf", ovf12, 0);
    step(0, 0, 0, 0, 1);

    // len=0 means 16 products, with random gaps on in_valid.
    a0 = accepts;
    while (accepts - a0 < 16) begin
      bit v;
      v = ($urandom_range(0, 2) != 0);
      step(v, 225, 0);
      if (accepts - a0 < 16) chk("r034_early", av12, 0);
    end
    chk("r034_sum", out12, 3600);
    chk("r034_ovf", ovf12, 0);
    step(0, 0, 0, 0, 1);

    // Carry past 8 bits sets ovf, cleared by the next sequence start.
    step(1, 200, 2);
    step(1, 100, 2);
    chk("r035_sum8", out8, 44);
    chk("r035_ovf8", ovf8, 1);
    step(0, 0, 0, 0, 1);
    step(1, 5, 1);
    chk("r035_next8", out8, 5);
    chk("r035_next_ovf8", ovf8, 0);

    // Hold with in_valid pending; handshake cycle must not accept.
    held = out12;
    for (int i = 0; i < 5; i++) begin
      step(1, 8'($urandom), 1);
      chk("r036_ready", rdy12, 0);
      chk("r036_stable", out12, held);
    end
    step(1, 77, 1, 0, 1);
    chk("r036_idle", busy12, 0);
    chk("r036_no_take", out12, held);

    // Clear after two accepts, concurrent product discarded.
    step(1, 30, 4);
    step(1, 40, 4);
    step(1, 50, 4, 1);
    chk("r037_out", out12, 0);
    chk("r037_busy", busy12, 0);
    step(1, 9, 1);
    chk("r037_fresh", out12, 9);
    step(0, 0, 0, 0, 1);

    // Reset in HOLD, reset in ACCUM, then ena=0 freeze mid-sequence.
    step(1, 11, 1);
    rst_n = 1'b0; step(1, 12, 3, 0, 0, 0); rst_n = 1'b1;
    chk("r038_hold_rst", av12, 0);
    step(1, 13, 3);
    rst_n = 1'b0; step(0, 0, 3); rst_n = 1'b1;
    chk("r038_acc_rst", out12, 0);
    step(1, 14, 3);
    for (int i = 0; i < 3; i++) step(1, 99, 1, 1, 1, 0);
    chk("r038_frozen", out12, 14);
    step(1, 15, 3);
    step(1, 16, 3);
    chk("r038_resume", out12, 45);
    step(0, 0, 0, 0, 1);

    // Randomized traffic including clears, stalls and occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      step($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom),
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 Parameter ACC_W, default 12, SHALL set the accumulator width in bits, legal range 8..16.
REQ-002 Port clk, input, 1, SHALL be the single system clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the synchronous active-low reset.
REQ-004 Port ena, input, 1, SHALL gate all state updates; ena=0 freezes every register.
REQ-005 Port p_in, input, 8, SHALL carry the unsigned product from the upstream 4x4 array multiplier.
REQ-006 Port in_valid, input, 1, SHALL indicate p_in holds a product to consume.
REQ-007 Port in_ready, output, 1, SHALL indicate the block accepts p_in this cycle.
REQ-008 Port len, input, 4, SHALL give the products per sum; 0 encodes 16; sampled at the first accept of a sequence.
REQ-009 Port clear, input, 1, SHALL abort the current sequence synchronously.
REQ-010 Port acc_out, output, ACC_W, SHALL present the accumulated sum.
REQ-011 Port acc_valid, output, 1, SHALL flag acc_out as a completed result.
REQ-012 Port acc_ready, input, 1, SHALL indicate the consumer takes the result.
REQ-013 Port ovf, output, 1, SHALL be a sticky overflow flag for the current sequence.
REQ-014 Port busy, output, 1, SHALL be high in any state other than IDLE.

Function
REQ-015 An accept SHALL occur on a rising edge with ena=1, in_valid=1 and in_ready=1.
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-017 In IDLE, in_ready SHALL be 1 and acc_valid SHALL be 0; acc_out SHALL keep the last result.
REQ-018 An accept in IDLE SHALL latch len (0 stored as 16), load acc=p_in zero-extended, set cnt=1 and clear ovf.
REQ-019 From IDLE after the first accept, the FSM SHALL go to HOLD if the latched length is 1, otherwise to ACCUM.
REQ-020 In ACCUM, in_ready SHALL be 1 and each accept SHALL compute acc=acc+p_in modulo 2^ACC_W and cnt=cnt+1.
REQ-021 ACCUM SHALL go to HOLD on the accept that makes cnt equal the latched length.
REQ-022 Any carry out of bit ACC_W-1 SHALL set ovf, which stays set until the next sequence starts.
REQ-023 In HOLD, acc_valid SHALL be 1, in_ready SHALL be 0, and acc_out and ovf SHALL be stable.
REQ-024 HOLD SHALL go to IDLE on the cycle acc_ready=1 with ena=1; in_valid in that same cycle SHALL NOT be accepted.
REQ-025 Latency: acc_valid SHALL rise on the clock edge that accepts the final product; there is no extra pipeline cycle.
REQ-026 A clear with ena=1 SHALL, from any state, force IDLE, acc=0, cnt=0 and ovf=0, and SHALL discard any concurrent accept.
REQ-027 clear SHALL take priority over accept and over acc_ready; rst_n SHALL take priority over clear.
REQ-028 When ena=0, in_ready SHALL read 0, and acc_valid and acc_out SHALL hold their values.
REQ-029 A change of len mid-sequence SHALL NOT affect the latched length.

Reset
REQ-030 With rst_n=0 at a rising edge, the block SHALL enter IDLE with acc_out=0, cnt=0, ovf=0, acc_valid=0 and busy=0, regardless of ena.
REQ-031 After that edge, in_ready SHALL read 1 whenever ena=1.
REQ-032 Reset asserted mid-sequence or in HOLD SHALL discard the partial or pending result.

Verification
REQ-033 len=4, four accepts of p_in=225 back-to-back -> acc_valid on the 4th accept edge, acc_out=900 (0x384), ovf=0.
REQ-034 len=0, sixteen accepts of 225 with random in_valid gaps -> acc_out=3600 (0xE10), ovf=0, acc_valid only after the 16th accept.
REQ-035 ACC_W=8, len=2, products 200 then 100 -> acc_out=44, ovf=1; the next sequence, with len=1 and p_in=5 -> acc_out=5, ovf=0.
REQ-036 Result in HOLD, acc_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, acc_out stable; acc_ready=1 -> IDLE next cycle, no accept in the handshake cycle.
REQ-037 len=4, clear asserted after 2 accepts together with in_valid=1 -> IDLE, acc_out=0, that product not accepted; a fresh len=1, p_in=9 sequence -> acc_out=9.
REQ-038 rst_n=0 asserted during HOLD and during ACCUM -> all outputs at reset values on the next edge; ena=0 for 3 cycles mid-sequence -> no state change.
